// File: rtl/phy_mgmt_sequencer.sv
// phy_mgmt_sequencer
//   Sequencer/arbiter in front of the MDIO controller. After reset it issues a
//   single PHY initialisation write, then periodically polls the PHY status
//   register to track link state, sharing the MDIO engine with one host
//   request port (host has priority over polls). A watchdog aborts
//   transactions that the engine never completes.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            host request handshake
//   req_write/req_reg/req_wdata    host request payload
//   rsp_valid/rsp_rdata/rsp_err    host response (single-cycle pulse)
//   mdio_start/mdio_mode/mdio_addr/mdio_reg_addr/mdio_wdata
//                                  command to the MDIO controller
//   mdio_rdata/mdio_done           completion from the MDIO controller
//   init_done                      init write finished (sticky until reset)
//   link_up                        BMSR link bit from the last poll
//   busy                           transaction outstanding (not IDLE)
module phy_mgmt_sequencer #(
    parameter logic [4:0]  PHY_ADDR  = 5'b00001,
    parameter logic [4:0]  INIT_REG  = 5'd0,
    parameter logic [15:0] INIT_DATA = 16'h1200,
    parameter logic [4:0]  STAT_REG  = 5'd1,
    parameter int unsigned POLL_DIV  = 1_000_000,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdio_start,
    output logic        mdio_mode,
    output logic [4:0]  mdio_addr,
    output logic [4:0]  mdio_reg_addr,
    output logic [15:0] mdio_wdata,
    input  logic [15:0] mdio_rdata,
    input  logic        mdio_done,
    output logic        init_done,
    output logic        link_up,
    output logic        busy
);

    localparam int unsigned POLL_W = $clog2(POLL_DIV);
    localparam int unsigned WD_W   = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              state, next_state;
    logic                owner_host, owner_host_d;
    logic [POLL_W-1:0]   poll_cnt, poll_cnt_d;
    logic                poll_pending, poll_pending_d;
    logic [WD_W-1:0]     wd_cnt, wd_cnt_d;

    logic                req_ready_d, rsp_valid_d, rsp_err_d, mdio_start_d;
    logic                mdio_mode_d, init_done_d, link_up_d, busy_d;
    logic [15:0]         rsp_rdata_d, mdio_wdata_d;
    logic [4:0]          mdio_reg_addr_d;

    logic                waiting_c;
    logic                timeout_c;
    logic                poll_wrap_c;
    logic                poll_clear_c;

    // Watchdog: wd_cnt equals cycles elapsed since the mdio_start cycle.
    assign waiting_c   = (state == S_WAIT) || (state == S_INIT_WAIT);
    assign timeout_c   = waiting_c && !mdio_start && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign poll_wrap_c = (poll_cnt == POLL_W'(POLL_DIV - 1));

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_INIT_ISSUE;
            owner_host    <= 1'b0;
            poll_cnt      <= '0;
            poll_pending  <= 1'b0;
            wd_cnt        <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 16'h0000;
            rsp_err       <= 1'b0;
            mdio_start    <= 1'b0;
            mdio_mode     <= 1'b0;
            mdio_addr     <= PHY_ADDR;
            mdio_reg_addr <= 5'd0;
            mdio_wdata    <= 16'h0000;
            init_done     <= 1'b0;
            link_up       <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state         <= next_state;
            owner_host    <= owner_host_d;
            poll_cnt      <= poll_cnt_d;
            poll_pending  <= poll_pending_d;
            wd_cnt        <= wd_cnt_d;
            req_ready     <= req_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_err       <= rsp_err_d;
            mdio_start    <= mdio_start_d;
            mdio_mode     <= mdio_mode_d;
            mdio_addr     <= PHY_ADDR;
            mdio_reg_addr <= mdio_reg_addr_d;
            mdio_wdata    <= mdio_wdata_d;
            init_done     <= init_done_d;
            link_up       <= link_up_d;
            busy          <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        next_state      = state;
        owner_host_d    = owner_host;
        rsp_valid_d     = 1'b0;
        rsp_rdata_d     = rsp_rdata;
        rsp_err_d       = 1'b0;
        mdio_start_d    = 1'b0;
        mdio_mode_d     = mdio_mode;
        mdio_reg_addr_d = mdio_reg_addr;
        mdio_wdata_d    = mdio_wdata;
        init_done_d     = init_done;
        link_up_d       = link_up;
        poll_clear_c    = 1'b0;

        case (state)
            S_INIT_ISSUE: begin
                mdio_mode_d     = 1'b0;
                mdio_reg_addr_d = INIT_REG;
                mdio_wdata_d    = INIT_DATA;
                mdio_start_d    = 1'b1;
                next_state      = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (mdio_done || timeout_c) begin
                    init_done_d = 1'b1;
                    next_state  = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    owner_host_d    = 1'b1;
                    mdio_mode_d     = !req_write;
                    mdio_reg_addr_d = req_reg;
                    mdio_wdata_d    = req_wdata;
                    mdio_start_d    = 1'b1;
                    next_state      = S_ISSUE;
                end else if (poll_pending) begin
                    owner_host_d    = 1'b0;
                    mdio_mode_d     = 1'b1;
                    mdio_reg_addr_d = STAT_REG;
                    mdio_wdata_d    = 16'h0000;
                    mdio_start_d    = 1'b1;
                    poll_clear_c    = 1'b1;
                    next_state      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // mdio_start is already high for this cycle
                next_state = S_WAIT;
            end
            S_WAIT: begin
                // A done in the timeout cycle still counts as success
                if (mdio_done) begin
                    if (owner_host) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = mdio_mode ? mdio_rdata : 16'h0000;
                    end else begin
                        link_up_d = mdio_rdata[2];
                    end
                    next_state = S_IDLE;
                end else if (timeout_c) begin
                    if (owner_host) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 16'h0000;
                    end else begin
                        link_up_d = 1'b0;
                    end
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_INIT_ISSUE;
        endcase

        req_ready_d = init_done_d && (next_state == S_IDLE);
        busy_d      = (next_state != S_IDLE);

        // Free-running poll timer; wraps collapse into one pending poll
        poll_cnt_d     = poll_wrap_c ? '0 : poll_cnt + POLL_W'(1);
        poll_pending_d = poll_wrap_c ? 1'b1 : (poll_clear_c ? 1'b0 : poll_pending);

        wd_cnt_d = mdio_start ? WD_W'(1) : (waiting_c ? wd_cnt + WD_W'(1) : '0);
    end

endmodule

// File: tb/tb_phy_mgmt_sequencer.sv
// Directed testbench for phy_mgmt_sequencer with a reactive MDIO controller model.
module tb_phy_mgmt_sequencer;

    localparam int unsigned POLL_DIV = 100;
    localparam int unsigned TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        mdio_start, mdio_mode;
    logic [4:0]  mdio_addr, mdio_reg_addr;
    logic [15:0] mdio_wdata, mdio_rdata;
    logic        mdio_done;
    logic        init_done, link_up, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Controller model state and event log
    int          cyc = 0;
    int          lat = 40;
    bit          drop = 1'b0;
    logic [15:0] stat_val = 16'h0000;
    logic [15:0] host_rdata = 16'h0000;
    int          m_cnt = 0;
    logic        m_rd = 1'b0;
    logic [4:0]  m_reg = 5'd0;
    int          n_starts = 0;
    int          n_rsp = 0;
    int          last_start_cyc = 0;
    int          last_done_cyc = 0;
    logic [4:0]  st_reg [64];

    phy_mgmt_sequencer #(
        .PHY_ADDR (5'b00001),
        .INIT_REG (5'd0),
        .INIT_DATA(16'h1200),
        .STAT_REG (5'd1),
        .POLL_DIV (POLL_DIV),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_reg      (req_reg),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mdio_start   (mdio_start),
        .mdio_mode    (mdio_mode),
        .mdio_addr    (mdio_addr),
        .mdio_reg_addr(mdio_reg_addr),
        .mdio_wdata   (mdio_wdata),
        .mdio_rdata   (mdio_rdata),
        .mdio_done    (mdio_done),
        .init_done    (init_done),
        .link_up      (link_up),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Controller model: answers each start after 'lat' cycles unless 'drop'
    initial begin
        mdio_done  = 1'b0;
        mdio_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            mdio_done = 1'b0;
            if (rst) begin
                m_cnt = 0;
            end else begin
                if (m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        mdio_done     = 1'b1;
                        mdio_rdata    = !m_rd ? 16'h0000 : (m_reg == 5'd1 ? stat_val : host_rdata);
                        last_done_cyc = cyc;
                    end
                end
                if (mdio_start) begin
                    if (n_starts < 64) st_reg[6'(n_starts)] = mdio_reg_addr;
                    n_starts       = n_starts + 1;
                    last_start_cyc = cyc;
                    m_rd           = mdio_mode;
                    m_reg          = mdio_reg_addr;
                    m_cnt          = drop ? 0 : lat;
                end
                if (rsp_valid) n_rsp = n_rsp + 1;
            end
        end
    end

    task automatic host_req(input logic wr, input logic [4:0] r, input logic [15:0] wd);
        bit ok = 1'b0;
        req_write = wr;
        req_reg   = r;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        if (!ok) check("host_accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_rsp();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("rsp_wait_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mdio_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("done_wait_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_poll_start();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mdio_start && mdio_mode && mdio_reg_addr == 5'd1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("poll_start_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int rel;
        int bad;
        int k0;
        int sc;
        int nr;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_reg   = 5'd0;
        req_wdata = 16'h0000;
        repeat (3) tick();

        // Reset values
        check("rst_req_ready",  32'(req_ready), 32'(0));
        check("rst_rsp_valid",  32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata",  32'(rsp_rdata), 32'(0));
        check("rst_rsp_err",    32'(rsp_err), 32'(0));
        check("rst_mdio_start", 32'(mdio_start), 32'(0));
        check("rst_mdio_mode",  32'(mdio_mode), 32'(0));
        check("rst_mdio_addr",  32'(mdio_addr), 32'(1));
        check("rst_mdio_reg",   32'(mdio_reg_addr), 32'(0));
        check("rst_mdio_wdata", 32'(mdio_wdata), 32'(0));
        check("rst_init_done",  32'(init_done), 32'(0));
        check("rst_link_up",    32'(link_up), 32'(0));
        check("rst_busy",       32'(busy), 32'(1));

        // Init write issued first cycle after reset release
        rst = 1'b0;
        rel = cyc;
        tick();
        check("init_start", 32'(mdio_start), 32'(1));
        check("init_mode",  32'(mdio_mode), 32'(0));
        check("init_reg",   32'(mdio_reg_addr), 32'(0));
        check("init_wdata", 32'(mdio_wdata), 32'h1200);
        check("init_addr",  32'(mdio_addr), 32'(1));

        // Host request before init completes is never accepted
        req_valid = 1'b1;
        req_write = 1'b1;
        req_reg   = 5'd7;
        req_wdata = 16'hFFFF;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_ready) bad++;
        end
        req_valid = 1'b0;
        check("preinit_not_ready", 32'(bad), 32'(0));

        wait_done();
        check("init_done_latency", 32'(cyc - last_start_cyc), 32'(40));
        check("init_done_early",   32'(init_done), 32'(0));
        tick();
        check("init_done_set",   32'(init_done), 32'(1));
        check("init_req_ready",  32'(req_ready), 32'(1));
        check("init_busy_clear", 32'(busy), 32'(0));
        check("init_one_start",  32'(n_starts), 32'(1));

        // First poll after the timer wrap, link up
        lat      = 10;
        stat_val = 16'h0004;
        wait_poll_start();
        check("poll1_cycle", 32'(cyc - rel), 32'(POLL_DIV + 1));
        wait_done();
        tick();
        check("poll1_link_up", 32'(link_up), 32'(1));
        check("poll1_ready",   32'(req_ready), 32'(1));

        // Next poll returns link down
        stat_val = 16'h0000;
        wait_poll_start();
        wait_done();
        tick();
        check("poll2_link_down", 32'(link_up), 32'(0));

        // Host read
        host_rdata = 16'hCC33;
        host_req(1'b0, 5'd5, 16'h0000);
        check("hrd_start", 32'(mdio_start), 32'(1));
        check("hrd_mode",  32'(mdio_mode), 32'(1));
        check("hrd_reg",   32'(mdio_reg_addr), 32'(5));
        wait_rsp();
        check("hrd_rsp_lat", 32'(cyc - last_done_cyc), 32'(1));
        check("hrd_rdata",   32'(rsp_rdata), 32'hCC33);
        check("hrd_err",     32'(rsp_err), 32'(0));
        check("hrd_ready",   32'(req_ready), 32'(1));
        tick();
        check("hrd_pulse",   32'(rsp_valid), 32'(0));

        // Host write
        host_req(1'b1, 5'd4, 16'hA5A5);
        check("hwr_start", 32'(mdio_start), 32'(1));
        check("hwr_mode",  32'(mdio_mode), 32'(0));
        check("hwr_reg",   32'(mdio_reg_addr), 32'(4));
        check("hwr_wdata", 32'(mdio_wdata), 32'hA5A5);
        wait_rsp();
        check("hwr_rdata", 32'(rsp_rdata), 32'(0));
        check("hwr_err",   32'(rsp_err), 32'(0));

        // Arbitration: back-to-back host requests spanning a timer wrap
        wait_poll_start();
        wait_done();
        lat = 60;
        k0  = n_starts;
        host_req(1'b0, 5'd3, 16'h0000);
        host_req(1'b0, 5'd6, 16'h0000);
        host_req(1'b0, 5'd9, 16'h0000);
        lat = 10;
        wait_poll_start();
        check("arb_poll_gap",  32'(cyc - last_done_cyc), 32'(2));
        check("arb_order0",    32'(st_reg[6'(k0)]), 32'(3));
        check("arb_order1",    32'(st_reg[6'(k0 + 1)]), 32'(6));
        check("arb_order2",    32'(st_reg[6'(k0 + 2)]), 32'(9));
        check("arb_order3",    32'(st_reg[6'(k0 + 3)]), 32'(1));
        wait_done();
        tick();

        // Host read timeout
        drop = 1'b1;
        host_req(1'b0, 5'd8, 16'h0000);
        sc = cyc;
        wait_rsp();
        drop = 1'b0;
        check("to_host_latency", 32'(cyc - sc), 32'(TIMEOUT));
        check("to_host_err",     32'(rsp_err), 32'(1));
        check("to_host_rdata",   32'(rsp_rdata), 32'(0));

        // Poll timeout forces link down
        stat_val = 16'h0004;
        wait_poll_start();
        wait_done();
        tick();
        check("to_poll_pre_link", 32'(link_up), 32'(1));
        drop = 1'b1;
        wait_poll_start();
        sc = cyc;
        repeat (TIMEOUT - 1) tick();
        check("to_poll_link_hold", 32'(link_up), 32'(1));
        tick();
        drop = 1'b0;
        check("to_poll_link_down", 32'(link_up), 32'(0));
        check("to_poll_busy",      32'(busy), 32'(0));

        // Reset in the middle of a host read
        lat = 30;
        host_req(1'b0, 5'd5, 16'h0000);
        repeat (5) tick();
        nr  = n_rsp;
        rst = 1'b1;
        tick();
        check("mrst_init_done", 32'(init_done), 32'(0));
        check("mrst_busy",      32'(busy), 32'(1));
        check("mrst_start",     32'(mdio_start), 32'(0));
        rst = 1'b0;
        lat = 40;
        tick();
        check("mrst_reinit_start", 32'(mdio_start), 32'(1));
        check("mrst_reinit_reg",   32'(mdio_reg_addr), 32'(0));
        check("mrst_reinit_wdata", 32'(mdio_wdata), 32'h1200);
        repeat (50) tick();
        check("mrst_no_rsp",    32'(n_rsp), 32'(nr));
        check("mrst_init_done2", 32'(init_done), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_mgmt_sequencer.md
# phy_mgmt_sequencer

Sequencer and arbiter in front of the MDIO `controller` block. After reset it issues one PHY initialisation write, then periodically polls the PHY status register to track link state. Between polls it shares the MDIO engine with a single host request port. The host port is granted priority over polls; a watchdog aborts transactions the engine never completes.

## Interface
Parameters:
- `PHY_ADDR`, 5'b00001, PHY address driven on every transaction.
- `INIT_REG`, 5'd0, register written once after reset (BMCR).
- `INIT_DATA`, 16'h1200, value for that write (autoneg enable + restart).
- `STAT_REG`, 5'd1, register polled for link (BMSR); link bit is bit 2.
- `POLL_DIV`, 1_000_000, clk cycles between poll requests (≥2).
- `TIMEOUT`, 4096, max cycles from `mdio_start` to `mdio_done` (≥2).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  request accepted on `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_reg`  in  5  host register address.
- `req_wdata`  in  16  host write data.
- `rsp_valid`  out  1  one-cycle pulse; host transaction finished.
- `rsp_rdata`  out  16  read data (0 for writes/errors), valid with `rsp_valid`.
- `rsp_err`  out  1  transaction timed out, valid with `rsp_valid`.
- `mdio_start`  out  1  one-cycle start pulse to controller.
- `mdio_mode`  out  1  1 = read, 0 = write (controller encoding).
- `mdio_addr`  out  5  PHY address (= `PHY_ADDR`).
- `mdio_reg_addr`  out  5  register address.
- `mdio_wdata`  out  16  write data.
- `mdio_rdata`  in  16  read data from controller, valid when `mdio_done`.
- `mdio_done`  in  1  one-cycle completion pulse from controller.
- `init_done`  out  1  init write finished (success or timeout).
- `link_up`  out  1  last poll's BMSR[2].
- `busy`  out  1  transaction outstanding.

## Operation
- States: INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT.
- INIT_ISSUE: load `INIT_REG`/`INIT_DATA`, mode 0, pulse `mdio_start` → INIT_WAIT.
- INIT_WAIT: on `mdio_done` or timeout → set `init_done` → IDLE. `init_done` stays 1 until reset.
- IDLE, in priority order: (1) `req_valid` → latch request, owner = HOST → ISSUE; (2) `poll_pending` → owner = POLL, mode 1, reg `STAT_REG` → ISSUE; (3) stay.
- ISSUE: pulse `mdio_start` for exactly one cycle → WAIT.
- WAIT: on `mdio_done`, HOST → pulse `rsp_valid`, `rsp_rdata = mdio_rdata` for reads and 0 for writes, `rsp_err = 0`. POLL → `link_up <= mdio_rdata[2]`. Then → IDLE.
- Timeout: watchdog counts cycles in WAIT/INIT_WAIT; on reaching `TIMEOUT` → abort. HOST gets `rsp_valid = 1`, `rsp_err = 1`, `rsp_rdata = 0`; POLL forces `link_up <= 0`. → IDLE. A `mdio_done` arriving in the same cycle as the timeout counts as success.
- Poll timer: free-running from reset, counts 0..`POLL_DIV`-1. At wrap, set `poll_pending`; cleared when a poll is issued. Multiple wraps while pending collapse into one poll.
- `mdio_mode`/`mdio_reg_addr`/`mdio_wdata`/`mdio_addr` are registered and held stable from ISSUE through the end of WAIT.
- `req_ready = init_done & (state == IDLE)`; host requests are never accepted before init completes.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset values: `req_ready` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `mdio_start` 0, `mdio_mode` 0, `mdio_addr` `PHY_ADDR`, `mdio_reg_addr` 0, `mdio_wdata` 0, `init_done` 0, `link_up` 0, `busy` 1; state INIT_ISSUE; poll timer 0; `poll_pending` 0.
- The first cycle after `rst` deasserts: `mdio_start` = 1 (init write).
- Accept in cycle N → `mdio_start` high in cycle N+1. `mdio_done` in cycle M → `rsp_valid`/`link_up` update in cycle M+1, `req_ready` high in M+1.
- Back-to-back: no more than one start per transaction. At least one IDLE cycle occurs between `mdio_done` and the next `mdio_start`.
- `mdio_done` outside WAIT/INIT_WAIT is ignored.
- Reset mid-transaction: all state returns to reset values within one cycle, and the init write is reissued. The controller shares `rst` with this block.

## Test plan
- Init: release reset, controller model answers `mdio_done` 40 cycles after start → exactly one write, reg 0, data 16'h1200, `init_done` = 1 the cycle after done, `req_ready` = 1.
- Poll: `POLL_DIV` = 100, model returns 16'h0004 → read of reg 1 issued after timer wrap, `link_up` = 1. The next poll returns 16'h0000 → `link_up` = 0.
- Host read: reg 5, model returns 16'hCC33 → `rsp_valid` pulse with `rsp_rdata` = 16'hCC33, `rsp_err` = 0. A host write of 16'hA5A5 to reg 4 → `mdio_wdata` = 16'hA5A5, `rsp_rdata` = 0.
- Arbitration: `req_valid` and `poll_pending` both present in IDLE → host transaction first, poll immediately after. A `req_valid` before `init_done` stays unaccepted.
- Timeout: `TIMEOUT` = 64, model never asserts done on a host read → `rsp_valid` with `rsp_err` = 1 exactly 64 cycles after start, `rsp_rdata` = 0. The same case on a poll → `link_up` = 0.
- Reset during WAIT of a host read → no `rsp_valid`, `init_done` = 0, init write reissued the first cycle after reset.
